// File: rtl/config_pkg.sv
// Shared types and default widths for the configuration shift-chain loader.
package config_pkg;

  localparam int unsigned CONFIG_WORD_W = 32;
  localparam int unsigned CONFIG_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_SET,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/config_serializer.sv
// Parallel-load, MSB-first left-shift register with a per-word bit counter.
module config_serializer
  import config_pkg::*;
#(
  parameter int unsigned WORD_W = CONFIG_WORD_W,
  parameter int unsigned BITS_W = $clog2(CONFIG_WORD_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_load_data,
  input  logic [BITS_W-1:0] i_load_bits,
  input  logic              i_shift,
  output logic              o_msb,
  output logic              o_last_bit
);

  logic [WORD_W-1:0] r_sreg;
  logic [BITS_W-1:0] r_bits;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sreg <= '0;
      r_bits <= '0;
    end else if (i_load) begin
      r_sreg <= i_load_data;
      r_bits <= i_load_bits;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[WORD_W-2:0], 1'b0};
      if (r_bits != '0) r_bits <= r_bits - BITS_W'(1);
    end
  end

  assign o_msb      = r_sreg[WORD_W-1];
  assign o_last_bit = (r_bits == BITS_W'(1));

endmodule

// File: rtl/config_loader.sv
// Configuration bitstream transmitter: FSM and chain-length counter feeding config_serializer.
// Optional readback capture of chain_return is enabled by defining CONFIG_LOADER_READBACK_EN.
module config_loader
  import config_pkg::*;
#(
  parameter int unsigned WORD_W = CONFIG_WORD_W,
  parameter int unsigned CNT_W  = CONFIG_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  chain_len,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              shift_enable,
  output logic              shift_out,
  output logic              set_hard,
  output logic              busy,
  output logic              done,
  input  logic              chain_return,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int unsigned BITS_W = $clog2(WORD_W + 1);

  loader_state_t     r_state;
  loader_state_t     w_next;
  logic [CNT_W-1:0]  r_remaining;
  logic [BITS_W-1:0] w_load_bits;
  logic              w_hs;
  logic              w_shift;
  logic              w_last_chain;
  logic              w_last_bit;
  logic              w_msb;

  assign w_hs         = (r_state == ST_FETCH) && word_valid;
  assign w_shift      = (r_state == ST_SHIFT);
  assign w_last_chain = (r_remaining == CNT_W'(1));

  // Final word of a short chain only carries its upper `remaining` bits.
  always_comb begin
    w_load_bits = BITS_W'(WORD_W);
    if (r_remaining < CNT_W'(WORD_W)) w_load_bits = BITS_W'(r_remaining);
  end

  config_serializer #(
    .WORD_W (WORD_W),
    .BITS_W (BITS_W)
  ) u_ser (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_load      (w_hs),
    .i_load_data (word_data),
    .i_load_bits (w_load_bits),
    .i_shift     (w_shift),
    .o_msb       (w_msb),
    .o_last_bit  (w_last_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && start) r_remaining <= chain_len;
      else if (w_shift && r_remaining != '0) r_remaining <= r_remaining - CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = (chain_len == '0) ? ST_SET : ST_FETCH;
      ST_FETCH: if (word_valid) w_next = ST_SHIFT;
      ST_SHIFT: begin
        if (w_last_chain)    w_next = ST_SET;
        else if (w_last_bit) w_next = ST_FETCH;
      end
      ST_SET:   w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign word_ready   = (r_state == ST_FETCH);
  assign shift_enable = w_shift;
  assign shift_out    = w_shift & w_msb;
  assign set_hard     = (r_state == ST_SET);
  assign done         = (r_state == ST_DONE);
  assign busy         = (r_state == ST_FETCH) || (r_state == ST_SHIFT) || (r_state == ST_SET);

`ifdef CONFIG_LOADER_READBACK_EN
  logic [WORD_W-1:0] r_rb_sreg;
  logic [WORD_W-1:0] r_rb_data;
  logic [BITS_W-1:0] r_rb_cnt;
  logic              r_rb_valid;
  logic [WORD_W-1:0] w_rb_next;
  logic [BITS_W-1:0] w_rb_cnt_next;
  logic              w_rb_emit;

  always_comb begin
    w_rb_next     = {r_rb_sreg[WORD_W-2:0], chain_return};
    w_rb_cnt_next = r_rb_cnt + BITS_W'(1);
    w_rb_emit     = w_shift && ((w_rb_cnt_next == BITS_W'(WORD_W)) || w_last_chain);
  end

  // A short final group sits in the low bits; shifting by the gap left-aligns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rb_sreg  <= '0;
      r_rb_data  <= '0;
      r_rb_cnt   <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= w_rb_emit;
      if (w_shift) begin
        if (w_rb_emit) begin
          r_rb_data <= w_rb_next << (BITS_W'(WORD_W) - w_rb_cnt_next);
          r_rb_sreg <= '0;
          r_rb_cnt  <= '0;
        end else begin
          r_rb_sreg <= w_rb_next;
          r_rb_cnt  <= w_rb_cnt_next;
        end
      end
    end
  end

  assign rb_data  = r_rb_data;
  assign rb_valid = r_rb_valid;
`else
  logic w_unused_chain_return;
  assign w_unused_chain_return = chain_return;
  assign rb_data  = '0;
  assign rb_valid = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Directed self-checking bench for config_loader (readback test active when CONFIG_LOADER_READBACK_EN is defined).
module tb_config_loader;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  chain_len = '0;
  logic              word_valid = 1'b0;
  logic [WORD_W-1:0] word_data = '0;
  logic              word_ready;
  logic              shift_enable;
  logic              shift_out;
  logic              set_hard;
  logic              busy;
  logic              done;
  logic              chain_return;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  logic [8:0] r_dly = '0;

  config_loader #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .chain_len    (chain_len),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready),
    .shift_enable (shift_enable),
    .shift_out    (shift_out),
    .set_hard     (set_hard),
    .busy         (busy),
    .done         (done),
    .chain_return (chain_return),
    .rb_data      (rb_data),
    .rb_valid     (rb_valid)
  );

  always #5 clk = ~clk;

  // Chain model: tail returns what entered the head nine cycles earlier.
  always @(posedge clk) r_dly <= {r_dly[7:0], shift_out};
  assign chain_return = r_dly[8];

  int n_tests = 0;
  int n_fail  = 0;

  logic [WORD_W-1:0] words[4];
  int                n_words;
  int                n_shift, n_set, n_done, n_hs, n_rdy, n_rb, n_rb_all;
  int                set_cyc, done_cyc, last_shift_cyc;
  logic [127:0]      stream;
  logic [WORD_W-1:0] rb_seen;
  logic              finished;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] out_vec();
    return {word_ready, shift_enable, shift_out, set_hard, busy, done, rb_valid};
  endfunction

  // stall_at: word index whose FETCH is held off for stall_len cycles; abort_at: cycle to pulse rst.
  task automatic run_load(input logic [CNT_W-1:0] len, input int stall_at, input int stall_len,
                          input int abort_at);
    int   idx       = 0;
    int   stall_cnt = 0;
    int   hs_cyc    = -10;
    logic wv;
    n_shift = 0; n_set = 0; n_done = 0; n_hs = 0; n_rdy = 0; n_rb = 0;
    set_cyc = -1; done_cyc = -1; last_shift_cyc = -1;
    stream = '0; rb_seen = '0; finished = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    chain_len = len;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == abort_at) begin
        check("pre_rst_shift", shift_enable, 1'b1);
        word_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check("rst_async_outputs", out_vec(), 7'd0);
        @(negedge clk);
        rst      = 1'b0;
        finished = 1'b1;
      end else begin
        if (shift_enable) begin
          stream = {stream[126:0], shift_out};
          n_shift++;
          last_shift_cyc = cyc;
        end
        if (set_hard) begin n_set++; set_cyc = cyc; end
        if (done) begin n_done++; done_cyc = cyc; finished = 1'b1; end
        if (rb_valid) begin n_rb++; n_rb_all++; rb_seen = rb_data; end
        if (word_ready) n_rdy++;
        if (cyc == hs_cyc + 1) check("resume_shift", shift_enable, 1'b1);
        if (word_ready && idx == stall_at && stall_cnt < stall_len) begin
          check("stall_no_shift", shift_enable, 1'b0);
          check("stall_busy", busy, 1'b1);
          stall_cnt++;
          wv = 1'b0;
        end else begin
          wv = (idx < n_words);
        end
        word_valid = wv;
        word_data  = (idx < n_words) ? words[idx] : '0;
        if (wv && word_ready) begin
          if (idx == stall_at && stall_len > 0) hs_cyc = cyc;
          n_hs++;
          idx++;
        end
      end
    end
    word_valid = 1'b0;
    check("load_finished", finished, 1'b1);
  endtask

  initial begin
    n_rb_all = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", out_vec(), 7'd0);
    check("reset_rb_data", rb_data, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two full words.
    words[0] = 32'hA5A5A5A5; words[1] = 32'h0F0F0F0F; n_words = 2;
    run_load(16'd64, -1, 0, -1);
    check("t64_shifts", n_shift, 64);
    check("t64_stream", stream, {64'h0, 64'hA5A5A5A50F0F0F0F});
    check("t64_handshakes", n_hs, 2);
    check("t64_set_once", n_set, 1);
    check("t64_set_after_shift", set_cyc, last_shift_cyc + 1);
    check("t64_done_cyc", done_cyc, 67);
    check("t64_done_once", n_done, 1);

    // Partial final word; a third word on offer must stay unconsumed.
    words[0] = 32'hFFFFFFFF; words[1] = 32'h80FF0000; words[2] = 32'h12345678; n_words = 3;
    run_load(16'd40, -1, 0, -1);
    check("t40_shifts", n_shift, 40);
    check("t40_stream", stream, {88'h0, 32'hFFFFFFFF, 8'h80});
    check("t40_handshakes", n_hs, 2);
    check("t40_set_cyc", set_cyc, 42);
    check("t40_done_cyc", done_cyc, 43);

    // Empty chain: straight to the latch pulse.
    words[0] = 32'hDEADBEEF; n_words = 1;
    run_load(16'd0, -1, 0, -1);
    check("t0_set_cyc", set_cyc, 0);
    check("t0_done_cyc", done_cyc, 1);
    check("t0_no_ready", n_rdy, 0);
    check("t0_no_shift", n_shift, 0);
    check("t0_no_handshake", n_hs, 0);

    // Host stalls five cycles before the second word.
    words[0] = 32'h13579BDF; words[1] = 32'h2468ACE0; n_words = 2;
    run_load(16'd64, 1, 5, -1);
    check("stall_shifts", n_shift, 64);
    check("stall_stream", stream, {64'h0, 64'h13579BDF2468ACE0});
    check("stall_done_cyc", done_cyc, 72);

    // Reset in the middle of shifting, then a clean reload.
    words[0] = 32'hFFFFFFFF; words[1] = 32'hFFFFFFFF; n_words = 2;
    run_load(16'd64, -1, 0, 10);
    check("abort_no_set", n_set, 0);
    n_set = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (set_hard || shift_enable) n_set++;
    end
    check("abort_quiet_after", n_set, 0);
    words[0] = 32'hDEADBEEF; n_words = 1;
    run_load(16'd32, -1, 0, -1);
    check("reload_shifts", n_shift, 32);
    check("reload_stream", stream, {96'h0, 32'hDEADBEEF});
    check("reload_set_once", n_set, 1);
    check("reload_done_cyc", done_cyc, 34);

    repeat (12) @(negedge clk);
`ifdef CONFIG_LOADER_READBACK_EN
    words[0] = 32'hC3A55A3C; n_words = 1;
    run_load(16'd32, -1, 0, -1);
    check("rb_pulses", n_rb, 1);
    check("rb_data", rb_seen, 32'h0061D2AD);
`else
    check("rb_valid_never", n_rb_all, 0);
    check("rb_data_zero", rb_data, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
